// File: rtl/tiny_control_unit_if.sv
// Instruction/data memory handshake bundle for tiny_control_unit.
// master = control unit side, slave = memory side.
interface tiny_control_unit_if #(
    parameter int PC_BITS = 8
);
    logic [PC_BITS-1:0] imem_addr;
    logic               imem_req;
    logic               imem_ack;
    logic [15:0]        imem_data;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;

    modport master (
        output imem_addr, imem_req, dmem_req, dmem_we,
        input  imem_ack, imem_data, dmem_ack
    );

    modport slave (
        input  imem_addr, imem_req, dmem_req, dmem_we,
        output imem_ack, imem_data, dmem_ack
    );
endinterface

// File: rtl/tiny_control_unit.sv
// Sequencer/decoder for the 16-bit TinyCPU datapath: fetch, decode, branches and memory handshakes.
// Optional illegal-opcode trap is enabled by defining TINY_CU_ILLEGAL_TRAP_EN.
module tiny_control_unit #(
    parameter int         BITS    = 16,
    parameter int         PC_BITS = 8,
    parameter logic [3:0] G_ADD   = 4'b0010,
    parameter logic [3:0] G_PASSA = 4'b0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    tiny_control_unit_if.master memBus,
    output logic                LoadEnable,
    output logic [1:0]          ASelect,
    output logic [1:0]          BSelect,
    output logic [1:0]          DestinationSelect,
    output logic [BITS-1:0]     ConstantIn,
    output logic                MBSelect,
    output logic                MDSelect,
    output logic                MFSelect,
    output logic [3:0]          GSelect,
    output logic [1:0]          HSelect,
    input  logic                statZ,
    input  logic                statN,
    input  logic [BITS-1:0]     jump_target,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} cuState_e;

    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd2;
    localparam logic [3:0] OP_SHIFT = 4'd3;
    localparam logic [3:0] OP_LD    = 4'd4;
    localparam logic [3:0] OP_ST    = 4'd5;
    localparam logic [3:0] OP_LDI   = 4'd6;
    localparam logic [3:0] OP_BZ    = 4'd7;
    localparam logic [3:0] OP_BN    = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [PC_BITS-1:0] PC_STEP = PC_BITS'(1);

    cuState_e           state;
    logic [PC_BITS-1:0] pc;
    logic [15:0]        ir;
    logic               imemReq;
    logic               dmemReq;
    logic               dmemWe;
    logic               haltedReg;

    logic [3:0]         opcode;
    logic [5:0]         imm6;
    logic [PC_BITS-1:0] branchOffset;
    logic               branchTaken;
    logic               writesInExec;
    logic               unusedJumpBits;

    assign opcode       = ir[15:12];
    assign imm6         = ir[5:0];
    assign branchOffset = {{(PC_BITS-6){imm6[5]}}, imm6};
    assign branchTaken  = ((opcode == OP_BZ) && statZ) || ((opcode == OP_BN) && statN);
    assign writesInExec = (opcode == OP_ALU) || (opcode == OP_ADDI) ||
                          (opcode == OP_SHIFT) || (opcode == OP_LDI);

    // Only the low PC_BITS of AddressOut form a jump target.
    assign unusedJumpBits = ^jump_target[BITS-1:PC_BITS];

`ifdef TINY_CU_ILLEGAL_TRAP_EN
    logic illegalReg;
    logic isIllegal;
    assign isIllegal = (opcode >= 4'd10) && (opcode <= 4'd14);
    assign illegal   = illegalReg;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            ir         <= '0;
            imemReq    <= 1'b0;
            dmemReq    <= 1'b0;
            dmemWe     <= 1'b0;
            haltedReg  <= 1'b0;
`ifdef TINY_CU_ILLEGAL_TRAP_EN
            illegalReg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= FETCH;
                        imemReq <= 1'b1;
                    end
                end
                FETCH: begin
                    if (memBus.imem_ack) begin
                        ir      <= memBus.imem_data;
                        pc      <= pc + PC_STEP;
                        imemReq <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Most opcodes return straight to fetch; the cases below override that.
                    state   <= FETCH;
                    imemReq <= 1'b1;
                    case (opcode)
                        OP_LD, OP_ST: begin
                            state   <= MEM;
                            imemReq <= 1'b0;
                            dmemReq <= 1'b1;
                            dmemWe  <= (opcode == OP_ST);
                        end
                        OP_BZ, OP_BN: begin
                            if (branchTaken) pc <= pc + branchOffset;
                        end
                        OP_JMP: pc <= jump_target[PC_BITS-1:0];
                        OP_HALT: begin
                            state     <= HALT;
                            imemReq   <= 1'b0;
                            haltedReg <= 1'b1;
                        end
`ifdef TINY_CU_ILLEGAL_TRAP_EN
                        default: begin
                            if (isIllegal) begin
                                state      <= HALT;
                                imemReq    <= 1'b0;
                                haltedReg  <= 1'b1;
                                illegalReg <= 1'b1;
                            end
                        end
`else
                        default: ;
`endif
                    endcase
                end
                MEM: begin
                    if (memBus.dmem_ack) begin
                        state   <= FETCH;
                        dmemReq <= 1'b0;
                        dmemWe  <= 1'b0;
                        imemReq <= 1'b1;
                    end
                end
                HALT: ;
                default: begin
                    state   <= IDLE;
                    imemReq <= 1'b0;
                    dmemReq <= 1'b0;
                    dmemWe  <= 1'b0;
                end
            endcase
        end
    end

    // Mux/function selects are only driven while an instruction is in flight.
    always_comb begin
        GSelect  = '0;
        HSelect  = '0;
        MBSelect = 1'b0;
        MDSelect = 1'b0;
        MFSelect = 1'b0;
        if ((state == EXEC) || (state == MEM)) begin
            case (opcode)
                OP_ALU:   GSelect = imm6[3:0];
                OP_ADDI: begin
                    GSelect  = G_ADD;
                    MBSelect = 1'b1;
                end
                OP_SHIFT: begin
                    MFSelect = 1'b1;
                    HSelect  = imm6[1:0];
                end
                OP_LD:    MDSelect = 1'b1;
                OP_LDI: begin
                    MFSelect = 1'b1;
                    MBSelect = 1'b1;
                end
                OP_BZ, OP_BN: GSelect = G_PASSA;
                default: ;
            endcase
        end
    end

    // A load writes back only in the ack cycle, so the write-enable follows dmem_ack directly.
    assign LoadEnable = ((state == EXEC) && writesInExec) ||
                        ((state == MEM) && (opcode == OP_LD) && memBus.dmem_ack);

    assign ASelect           = ir[9:8];
    assign BSelect           = ir[7:6];
    assign DestinationSelect = ir[11:10];
    assign ConstantIn        = {{(BITS-6){imm6[5]}}, imm6};

    assign memBus.imem_addr = pc;
    assign memBus.imem_req  = imemReq;
    assign memBus.dmem_req  = dmemReq;
    assign memBus.dmem_we   = dmemWe;
    assign halted           = haltedReg;

endmodule
